// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshake and persistent NZCV flags.
// Single-cycle arithmetic/logic/shift ops complete at the accept edge; MUL runs an
// iterative shift-add over WIDTH cycles, during which in_ready is low.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid, in_ready  op handshake (accept = in_valid & in_ready at rising edge)
//   op, a, b, set_flags opcode, operands, flag-update request (sampled at accept)
//   result, out_valid   registered result, one-cycle completion pulse
//   flags               registered {N,Z,C,V}
module alu_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             set_flags,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic [3:0]       flags
);

    localparam logic [3:0] OpAdd = 4'd0;
    localparam logic [3:0] OpSub = 4'd1;
    localparam logic [3:0] OpRsb = 4'd2;
    localparam logic [3:0] OpAnd = 4'd3;
    localparam logic [3:0] OpOrr = 4'd4;
    localparam logic [3:0] OpEor = 4'd5;
    localparam logic [3:0] OpMov = 4'd6;
    localparam logic [3:0] OpMvn = 4'd7;
    localparam logic [3:0] OpCmp = 4'd8;
    localparam logic [3:0] OpTst = 4'd9;
    localparam logic [3:0] OpLsl = 4'd10;
    localparam logic [3:0] OpLsr = 4'd11;
    localparam logic [3:0] OpAsr = 4'd12;
    localparam logic [3:0] OpMul = 4'd13;

    typedef enum logic {StIdle, StMul} state_e;

    state_e           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic             mul_sf_q, mul_sf_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             out_valid_q, out_valid_d;
    logic [3:0]       flags_q, flags_d;

    logic [WIDTH-1:0] add_x, add_y;
    logic             add_cin;
    logic [WIDTH:0]   add_sum;
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   shl, shr, sar;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v, alu_upd;
    logic [WIDTH-1:0] acc_step;
    logic             accept;

    assign in_ready = (state_q != StMul) & ~rst;
    assign accept   = in_valid & in_ready;
    assign shamt    = b[SHW-1:0];

    // One shared adder; SUB/CMP/RSB feed the inverted operand with carry-in set.
    always_comb begin
        add_x   = a;
        add_y   = b;
        add_cin = 1'b0;
        case (op)
            OpSub, OpCmp: begin
                add_y   = ~b;
                add_cin = 1'b1;
            end
            OpRsb: begin
                add_x   = b;
                add_y   = ~a;
                add_cin = 1'b1;
            end
            default: ;
        endcase
    end

    assign add_sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};

    // Shifts carry one extra bit so the last bit shifted out lands in a fixed position.
    assign shl = {1'b0, a} << shamt;
    assign shr = {a, 1'b0} >> shamt;
    assign sar = $signed({a, 1'b0}) >>> shamt;

    always_comb begin
        alu_res = '0;
        alu_c   = flags_q[1];
        alu_v   = flags_q[0];
        alu_upd = set_flags;
        case (op)
            OpAdd, OpSub, OpRsb, OpCmp: begin
                alu_res = add_sum[WIDTH-1:0];
                alu_c   = add_sum[WIDTH];
                alu_v   = (add_x[WIDTH-1] == add_y[WIDTH-1]) &&
                          (add_sum[WIDTH-1] != add_x[WIDTH-1]);
            end
            OpAnd, OpTst: alu_res = a & b;
            OpOrr:        alu_res = a | b;
            OpEor:        alu_res = a ^ b;
            OpMov:        alu_res = b;
            OpMvn:        alu_res = ~b;
            OpLsl: begin
                alu_res = shl[WIDTH-1:0];
                if (shamt != '0) alu_c = shl[WIDTH];
            end
            OpLsr: begin
                alu_res = shr[WIDTH:1];
                if (shamt != '0) alu_c = shr[0];
            end
            OpAsr: begin
                alu_res = sar[WIDTH:1];
                if (shamt != '0) alu_c = sar[0];
            end
            default: alu_upd = 1'b0;  // reserved opcodes; MUL completes elsewhere
        endcase
        if (op == OpCmp || op == OpTst) alu_upd = 1'b1;
    end

    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        mul_sf_d    = mul_sf_q;
        result_d    = result_q;
        out_valid_d = 1'b0;
        flags_d     = flags_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (op == OpMul) begin
                        state_d  = StMul;
                        cnt_d    = SHW'(WIDTH - 1);
                        acc_d    = '0;
                        mcand_d  = a;
                        mplier_d = b;
                        mul_sf_d = set_flags;
                    end else begin
                        result_d    = alu_res;
                        out_valid_d = 1'b1;
                        if (alu_upd) flags_d = {alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v};
                    end
                end
            end
            StMul: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - SHW'(1);
                if (cnt_q == '0) begin
                    state_d     = StIdle;
                    cnt_d       = '0;
                    result_d    = acc_step;
                    out_valid_d = 1'b1;
                    // MUL leaves C and V untouched
                    if (mul_sf_q) flags_d[3:2] = {acc_step[WIDTH-1], acc_step == '0};
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            mul_sf_q    <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            flags_q     <= 4'b0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            mul_sf_q    <= mul_sf_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            flags_q     <= flags_d;
        end
    end

    assign result    = result_q;
    assign out_valid = out_valid_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector table, multi-cycle MUL/reset sequences, and random ops
// checked against a plain-arithmetic reference model of alu_seq (WIDTH=32).
module tb_alu_seq;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         set_flags;
    logic [W-1:0] result;
    logic         out_valid;
    logic [3:0]   flags;

    int checks   = 0;
    int failures = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .set_flags (set_flags),
        .result    (result),
        .out_valid (out_valid),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sf;
        logic [W-1:0] res;
        logic [3:0]   nzcv;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic s);
        in_valid  = 1'b1;
        op        = o;
        a         = x;
        b         = y;
        set_flags = s;
    endtask

    // Reference model: straight arithmetic on the opcode definitions.
    function automatic void ref_exec(input logic [3:0] o, input logic [W-1:0] x,
                                     input logic [W-1:0] y, input logic sf,
                                     input logic [3:0] fin, output logic [W-1:0] r,
                                     output logic [3:0] fo);
        longint sx  = longint'($signed(x));
        longint sy  = longint'($signed(y));
        longint exact;
        logic   c   = fin[1];
        logic   v   = fin[0];
        logic   upd = sf || o == 4'd8 || o == 4'd9;
        int     n   = int'(y % W);
        logic [63:0] wide;
        case (o)
            4'd0: begin
                r     = x + y;
                wide  = {32'b0, x} + {32'b0, y};
                c     = wide > 64'hFFFF_FFFF;
                exact = sx + sy;
                v     = exact != longint'($signed(r));
            end
            4'd1, 4'd8: begin
                r     = x - y;
                c     = x >= y;
                exact = sx - sy;
                v     = exact != longint'($signed(r));
            end
            4'd2: begin
                r     = y - x;
                c     = y >= x;
                exact = sy - sx;
                v     = exact != longint'($signed(r));
            end
            4'd3, 4'd9: r = x & y;
            4'd4: r = x | y;
            4'd5: r = x ^ y;
            4'd6: r = y;
            4'd7: r = ~y;
            4'd10: begin
                r = x << n;
                if (n != 0) c = x[W-n];
            end
            4'd11: begin
                r = x >> n;
                if (n != 0) c = x[n-1];
            end
            4'd12: begin
                r = $signed(x) >>> n;
                if (n != 0) c = x[n-1];
            end
            4'd13: begin
                wide = {32'b0, x} * {32'b0, y};
                r    = wide[W-1:0];
            end
            default: begin
                r   = '0;
                upd = 1'b0;
            end
        endcase
        fo = upd ? {r[W-1], r == '0, c, v} : fin;
        if (o == 4'd13 && upd) fo = {r[W-1], r == '0, fin[1], fin[0]};
    endfunction

    initial begin
        int          lat;
        int          low;
        int          bad;
        logic [3:0]  ro;
        logic [W-1:0] ra, rb, er;
        logic        rsf;
        logic [3:0]  mflags, ef;

        vecs[0]  = '{4'd0,  32'h7FFF_FFFF, 32'h1,         1'b1, 32'h8000_0000, 4'b1001};
        vecs[1]  = '{4'd8,  32'h5,         32'h5,         1'b0, 32'h0,         4'b0110};
        vecs[2]  = '{4'd2,  32'h3,         32'h1,         1'b1, 32'hFFFF_FFFE, 4'b1000};
        vecs[3]  = '{4'd11, 32'h3,         32'h1,         1'b1, 32'h1,         4'b0010};
        vecs[4]  = '{4'd10, 32'h5,         32'h20,        1'b1, 32'h5,         4'b0010};
        vecs[5]  = '{4'd12, 32'h8000_0000, 32'd31,        1'b1, 32'hFFFF_FFFF, 4'b1000};
        vecs[6]  = '{4'd3,  32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 32'hF000_F000, 4'b1000};
        vecs[7]  = '{4'd5,  32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 32'h0FF0_0FF0, 4'b1000};
        vecs[8]  = '{4'd7,  32'h0,         32'h0000_FFFF, 1'b0, 32'hFFFF_0000, 4'b1000};
        vecs[9]  = '{4'd9,  32'h0F,        32'hF0,        1'b0, 32'h0,         4'b0100};
        vecs[10] = '{4'd14, 32'h1,         32'h1,         1'b1, 32'h0,         4'b0100};
        vecs[11] = '{4'd1,  32'h0,         32'h1,         1'b1, 32'hFFFF_FFFF, 4'b1000};
        vecs[12] = '{4'd0,  32'hFFFF_FFFF, 32'h1,         1'b1, 32'h0,         4'b0110};
        vecs[13] = '{4'd1,  32'h8000_0000, 32'h1,         1'b1, 32'h7FFF_FFFF, 4'b0011};
        vecs[14] = '{4'd4,  32'h1,         32'h2,         1'b1, 32'h3,         4'b0011};
        vecs[15] = '{4'd6,  32'h1234,      32'h0,         1'b1, 32'h0,         4'b0111};
        vecs[16] = '{4'd10, 32'h8000_0001, 32'h1,         1'b1, 32'h2,         4'b0011};

        rst       = 1'b1;
        in_valid  = 1'b0;
        op        = '0;
        a         = '0;
        b         = '0;
        set_flags = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_ready_low", {63'b0, in_ready}, 64'd0);
        check("rst_valid", {63'b0, out_valid}, 64'd0);
        check("rst_result", {32'b0, result}, 64'd0);
        check("rst_flags", {60'b0, flags}, 64'd0);
        rst = 1'b0;
        #1;
        check("rst_ready_high", {63'b0, in_ready}, 64'd1);

        // Back-to-back single-cycle vectors
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sf);
            tick();
            check($sformatf("tbl%0d_valid", i), {63'b0, out_valid}, 64'd1);
            check($sformatf("tbl%0d_result", i), {32'b0, result}, {32'b0, vecs[i].res});
            check($sformatf("tbl%0d_flags", i), {60'b0, flags}, {60'b0, vecs[i].nzcv});
        end
        in_valid = 1'b0;
        tick();
        check("idle_valid_low", {63'b0, out_valid}, 64'd0);
        check("idle_result_hold", {32'b0, result}, 64'h2);

        // MUL with a held follow-on op
        drive(4'd13, 32'h0000_FFFF, 32'h0001_0001, 1'b1);
        tick();
        drive(4'd0, 32'h1, 32'h2, 1'b0);
        lat = -1;
        low = 0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid) begin
                lat = k;
                break;
            end
            if (!in_ready) low++;
            tick();
        end
        check("mul_latency", 64'(lat), 64'd32);
        check("mul_ready_low_cycles", 64'(low), 64'd32);
        check("mul_result", {32'b0, result}, 64'hFFFF_FFFF);
        check("mul_flags", {60'b0, flags}, 64'b1011);
        check("mul_ready_back", {63'b0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        check("held_op_valid", {63'b0, out_valid}, 64'd1);
        check("held_op_result", {32'b0, result}, 64'h3);
        check("held_op_flags", {60'b0, flags}, 64'b1011);

        // Reset in the middle of a MUL
        drive(4'd13, 32'h3, 32'h5, 1'b1);
        tick();
        in_valid = 1'b0;
        bad = 0;
        for (int k = 0; k < 9; k++) begin
            if (out_valid) bad++;
            tick();
        end
        rst = 1'b1;
        tick();
        check("abort_ready_in_rst", {63'b0, in_ready}, 64'd0);
        check("abort_result", {32'b0, result}, 64'd0);
        check("abort_flags", {60'b0, flags}, 64'd0);
        rst = 1'b0;
        #1;
        check("abort_ready_after", {63'b0, in_ready}, 64'd1);
        for (int k = 0; k < 40; k++) begin
            tick();
            if (out_valid) bad++;
        end
        check("abort_no_valid", 64'(bad), 64'd0);

        // Random ops against the model
        mflags = 4'b0000;
        for (int n = 0; n < 300; n++) begin
            in_valid = 1'b0;
            for (int g = $urandom_range(0, 2); g > 0; g--) tick();
            ro  = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = $urandom;
            rsf = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) rb = ra;
            if (ro >= 4'd10 && ro <= 4'd12) rb = $urandom_range(0, 63);
            if ($urandom_range(0, 15) == 0) ra = 32'h8000_0000;
            ref_exec(ro, ra, rb, rsf, mflags, er, ef);
            check("rnd_ready", {63'b0, in_ready}, 64'd1);
            drive(ro, ra, rb, rsf);
            tick();
            lat = -1;
            for (int k = 0; k < int'(W) + 4; k++) begin
                if (out_valid) begin
                    lat = k;
                    break;
                end
                // Garbage on the inputs while busy must be ignored
                in_valid  = 1'($urandom_range(0, 1));
                op        = 4'($urandom_range(0, 15));
                a         = $urandom;
                b         = $urandom;
                set_flags = 1'($urandom_range(0, 1));
                tick();
            end
            in_valid = 1'b0;
            check($sformatf("rnd%0d_op%0d_latency", n, ro), 64'(lat),
                  (ro == 4'd13) ? 64'(W) : 64'd0);
            check($sformatf("rnd%0d_op%0d_result", n, ro), {32'b0, result}, {32'b0, er});
            check($sformatf("rnd%0d_op%0d_flags", n, ro), {60'b0, flags}, {60'b0, ef});
            mflags = ef;
        end
        tick();
        check("final_valid_low", {63'b0, out_valid}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
